// File: rtl/gshare_predictor_pkg.sv
// Shared types and constants for the gshare branch predictor.
// Holds the 2-bit saturating counter type and the in-flight entry layout.
package gshare_predictor_pkg;

    localparam int BP_GHR_W      = 8;
    localparam int BP_FIFO_DEPTH = 4;

    typedef logic [1:0] bp_ctr_t;

    typedef struct packed {
        logic [BP_GHR_W-1:0] idx;
        logic                pred;
    } bp_entry_t;

    function automatic bp_ctr_t bp_ctr_update(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != 2'b00)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_predictor_inflight_fifo.sv
// Circular buffer of unresolved predictions between IF and EX.
// Pop only when non-empty; push accepted when not full or popping; clear wins over push.
module bp_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch predictor with speculative/architectural history and
// an in-flight FIFO so EX resolution trains the exact PHT entry used at predict time.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int      GHR_W      = BP_GHR_W,
    parameter int      FIFO_DEPTH = BP_FIFO_DEPTH,
    parameter bp_ctr_t CTR_INIT   = 2'b01
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          lookup_valid,
    input  logic [31:0]                   lookup_pc,
    output logic                          prediction,
    input  logic                          resolve_valid,
    input  logic                          resolve_taken,
    input  logic                          squash,
    output logic                          mispredict,
    output logic [$clog2(FIFO_DEPTH):0]   inflight,
    output logic                          err_overflow,
    output logic                          err_underflow
);

    typedef struct packed {
        logic [GHR_W-1:0] idx;
        logic             pred;
    } entry_t;

    bp_ctr_t          pht [2**GHR_W];
    logic [GHR_W-1:0] spec_ghr;
    logic [GHR_W-1:0] arch_ghr;
    logic [GHR_W-1:0] spec_nxt;
    logic [GHR_W-1:0] arch_nxt;
    logic [GHR_W-1:0] idx;
    entry_t           head;
    entry_t           wentry;
    logic             full;
    logic             empty;
    logic             resolve_ok;
    logic             kill;
    logic             push_ok;
    logic             overflow;
    logic             unused_pc;

    assign unused_pc  = ^{lookup_pc[31:GHR_W+2], lookup_pc[1:0]};

    assign idx        = lookup_pc[GHR_W+1:2] ^ spec_ghr;
    assign prediction = lookup_valid & pht[idx][1];

    assign resolve_ok = resolve_valid & ~empty;
    assign mispredict = resolve_ok & (resolve_taken != head.pred);
    assign kill       = mispredict | squash;
    assign push_ok    = lookup_valid & ~kill & (~full | resolve_ok);
    assign overflow   = lookup_valid & ~kill & full & ~resolve_ok;
    assign wentry     = '{idx: idx, pred: prediction};

    // A redirect rebuilds speculative history from the post-resolve architectural history.
    always_comb begin
        arch_nxt = arch_ghr;
        if (resolve_ok)
            arch_nxt = {arch_ghr[GHR_W-2:0], resolve_taken};
        spec_nxt = spec_ghr;
        if (kill)
            spec_nxt = arch_nxt;
        else if (push_ok)
            spec_nxt = {spec_ghr[GHR_W-2:0], prediction};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spec_ghr      <= '0;
            arch_ghr      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            spec_ghr <= spec_nxt;
            arch_ghr <= arch_nxt;
            if (overflow)
                err_overflow <= 1'b1;
            if (resolve_valid && empty)
                err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**GHR_W; i++)
                pht[i] <= CTR_INIT;
        end else if (resolve_ok) begin
            pht[head.idx] <= bp_ctr_update(pht[head.idx], resolve_taken);
        end
    end

    bp_inflight_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .pop     (resolve_ok),
        .clear   (kill),
        .wdata   (wentry),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (inflight)
    );

endmodule
